// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding and default
// operand width, common to the sequential multiplier and divider.
package arith_pkg;

    localparam int unsigned ARITH_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE
    } arith_state_e;

endpackage

// File: rtl/mul_control.sv
// Sequencer for the shift-add multiplier: IDLE/CALC/DONE FSM, step counter,
// registered Ready/Busy, and load/step enables for the datapath.
// Ports: clk_i, rst_ni (async active-low), run_i, mplier_zero_i (only with
// EARLY_TERM_EN: post-shift multiplier is zero), load_o, step_o, ready_o,
// busy_o.
module mul_control
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_WIDTH
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
`ifdef EARLY_TERM_EN
    input  logic mplier_zero_i,
`endif
    output logic load_o,
    output logic step_o,
    output logic ready_o,
    output logic busy_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    arith_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;
    logic             busy_q;
    logic             last_step;

    // Operands are accepted only outside CALC; CALC ignores Run.
    assign load_o = run_i && (state_q != S_CALC);
    assign step_o = (state_q == S_CALC);

`ifdef EARLY_TERM_EN
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1)) || mplier_zero_i;
`else
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (run_i) begin
                        state_q <= S_CALC;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        state_q <= S_DONE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier, one add-shift step per clock.
// Ports: clk, Reset_n (async active-low), Run, Multiplicand, Multiplier,
// Product (2*WIDTH, valid under Ready), Ready, Busy.
// Optional EARLY_TERM_EN: finish as soon as no multiplier bits remain.
module seq_multiplier
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_WIDTH
) (
    input  logic               clk,
    input  logic               Reset_n,
    input  logic               Run,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic [2*WIDTH-1:0] Product,
    output logic               Ready,
    output logic               Busy
);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               load;
    logic               step;

`ifdef EARLY_TERM_EN
    // Value mplier_q takes after this step's shift.
    logic mplier_zero;
    assign mplier_zero = (mplier_q[WIDTH-1:1] == '0);
`endif

    mul_control #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk_i         (clk),
        .rst_ni        (Reset_n),
        .run_i         (Run),
`ifdef EARLY_TERM_EN
        .mplier_zero_i (mplier_zero),
`endif
        .load_o        (load),
        .step_o        (step),
        .ready_o       (Ready),
        .busy_o        (Busy)
    );

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, Multiplicand};
            mplier_d = Multiplier;
            prod_d   = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    assign Product = prod_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: scoreboard of expected products,
// latency model aware of EARLY_TERM_EN.
module tb_seq_multiplier;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           Reset_n;
    logic           Run;
    logic [W-1:0]   Multiplicand;
    logic [W-1:0]   Multiplier;
    logic [2*W-1:0] Product;
    logic           Ready;
    logic           Busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2*W-1:0] exp_q[$];

    seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Product      (Product),
        .Ready        (Ready),
        .Busy         (Busy)
    );

    always #5 clk = ~clk;

    function automatic int calc_cycles(input logic [W-1:0] b);
`ifdef EARLY_TERM_EN
        int h;
        h = 0;
        for (int i = 0; i < W; i++) if (b[i]) h = i + 1;
        return (h == 0) ? 1 : h;
`else
        return W;
`endif
    endfunction

    function automatic logic [2*W-1:0] pop_exp();
        if (exp_q.size() == 0) return '1;
        return exp_q.pop_front();
    endfunction

    // Drive one accepted Run; returns #1 after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        Run = 1'b1;
        Multiplicand = a;
        Multiplier = b;
        exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
        @(posedge clk);
        #1;
        Run = 1'b0;
    endtask

    // Counts edges until Ready; flags any non-Busy cycle before it.
    task automatic wait_ready(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (Ready !== 1'b1 && lat < 2 * W + 8) begin
            if (Busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Run = 1'b0;
        Multiplicand = '0;
        Multiplier = '0;
        #12;
        tests_run++;
        if ({Product, Ready, Busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: P=%h R=%b B=%b, need 0/0/0",
                     Product, Ready, Busy);
        end
        @(negedge clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (Ready !== 1'b0 || Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: R=%b B=%b, need 0/0", Ready, Busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        bit bok;
        logic [2*W-1:0] e;
        issue(32'd3, 32'd5);
        wait_ready(lat, bok);
        e = pop_exp();
        tests_run++;
        if (lat != calc_cycles(32'd5) || !bok) begin
            tests_failed++;
            $display("FAIL basic_latency: lat=%0d busy_ok=%0d, need %0d/1",
                     lat, bok, calc_cycles(32'd5));
        end
        tests_run++;
        if (Product !== e || e !== 64'd15) begin
            tests_failed++;
            $display("FAIL basic_product: got %h, need %h", Product, e);
        end
        tests_run++;
        if (Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy_done: got %b, need 0", Busy);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (Product !== 64'd15 || Ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_hold: P=%h R=%b, need 15/1", Product, Ready);
        end
    endtask

    task automatic test_operands(input logic [W-1:0] a[2],
                                 input logic [W-1:0] b[2],
                                 input string nm);
        int lat;
        bit bok;
        logic [2*W-1:0] e;
        for (int i = 0; i < 2; i++) begin
            issue(a[i], b[i]);
            wait_ready(lat, bok);
            e = pop_exp();
            tests_run++;
            if (Product !== e || lat != calc_cycles(b[i]) || !bok) begin
                tests_failed++;
                $display("FAIL %s[%0d]: P=%h lat=%0d, need P=%h lat=%0d",
                         nm, i, Product, lat, e, calc_cycles(b[i]));
            end
        end
    endtask

    task automatic test_max();
        test_operands('{32'hFFFFFFFF, 32'h80000000},
                      '{32'hFFFFFFFF, 32'd2}, "max");
        tests_run++;
        if (Product !== 64'h0000000100000000) begin
            tests_failed++;
            $display("FAIL max_const: got %h, need 0000000100000000", Product);
        end
    endtask

    task automatic test_zero();
        test_operands('{32'd0, 32'hDEADBEEF},
                      '{32'h12345678, 32'd0}, "zero");
    endtask

    task automatic test_protocol();
        int lat;
        bit bok;
        logic [2*W-1:0] e;
        issue(32'd6, 32'd7);
        @(negedge clk);
        Run = 1'b1;
        Multiplicand = 32'd7;
        Multiplier = 32'd9;
        @(negedge clk);
        Run = 1'b0;
        #1;
        wait_ready(lat, bok);
        e = pop_exp();
        tests_run++;
        if (Product !== 64'd42 || Product !== e) begin
            tests_failed++;
            $display("FAIL protocol_ignore: got %h, need %h", Product, e);
        end
        issue(32'd7, 32'd9);
        tests_run++;
        if (Ready !== 1'b0 || Busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL protocol_drop: R=%b B=%b, need 0/1", Ready, Busy);
        end
        wait_ready(lat, bok);
        e = pop_exp();
        tests_run++;
        if (Product !== e || lat != calc_cycles(32'd9)) begin
            tests_failed++;
            $display("FAIL protocol_reload: P=%h lat=%0d, need %h/%0d",
                     Product, lat, e, calc_cycles(32'd9));
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit bok;
        logic [2*W-1:0] e;
        issue(32'h1234, 32'hFFFFFFFF);
        repeat (9) @(negedge clk);
        #2;
        Reset_n = 1'b0;
        #1;
        exp_q.delete();
        tests_run++;
        if (Product !== '0 || Ready !== 1'b0 || Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: P=%h R=%b B=%b, need 0/0/0",
                     Product, Ready, Busy);
        end
        @(negedge clk);
        Reset_n = 1'b1;
        issue(32'd12, 32'd12);
        wait_ready(lat, bok);
        e = pop_exp();
        tests_run++;
        if (Product !== 64'd144 || Product !== e || lat != calc_cycles(32'd12)) begin
            tests_failed++;
            $display("FAIL reset_recover: P=%h lat=%0d, need %h/%0d",
                     Product, lat, e, calc_cycles(32'd12));
        end
    endtask

    task automatic test_back_to_back();
        int p;
        int highs;
        logic [2*W-1:0] e;
        p = calc_cycles(32'd3) + 1;
        highs = 0;
        @(negedge clk);
        Run = 1'b1;
        Multiplicand = 32'd2;
        Multiplier = 32'd3;
        for (int i = 0; i < 3; i++) exp_q.push_back(64'd6);
        for (int i = 0; i < 3 * p; i++) begin
            @(posedge clk);
            #1;
            if (Ready === 1'b1) begin
                highs++;
                e = pop_exp();
                tests_run++;
                if (Product !== e) begin
                    tests_failed++;
                    $display("FAIL b2b_product: got %h, need %h", Product, e);
                end
            end
        end
        Run = 1'b0;
        tests_run++;
        if (highs != 3) begin
            tests_failed++;
            $display("FAIL b2b_ready_pulses: got %0d, need 3", highs);
        end
        repeat (W + 2) @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_early_term();
        test_operands('{32'hDEADBEEF, 32'hDEADBEEF},
                      '{32'd1, 32'h00000100}, "lat_a");
        test_operands('{32'd5, 32'hDEADBEEF},
                      '{32'd0, 32'd1}, "lat_b");
        tests_run++;
        if (Product !== 64'h00000000DEADBEEF) begin
            tests_failed++;
            $display("FAIL et_product: got %h, need 00000000DEADBEEF", Product);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_protocol();
        test_reset_mid();
        test_zero();
        test_back_to_back();
        test_early_term();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
